// File: rtl/mips_mc_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : State encoding, opcode/funct constants and control-word type for
//            the multicycle MIPS control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_RTEXE   = 4'd7,
        ST_RTWB    = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_ADDIEXE = 4'd11,
        ST_ADDIWB  = 4'd12,
        ST_HALT    = 4'd13
    } state_e;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;
    localparam logic [5:0] c_fn_nor = 6'b100111;
    localparam logic [5:0] c_fn_xor = 6'b100110;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_nor = 4'b1100;
    localparam logic [3:0] c_alu_xor = 4'b1101;

    localparam logic [1:0] c_srcb_b   = 2'b00;
    localparam logic [1:0] c_srcb_one = 2'b01;
    localparam logic [1:0] c_srcb_imm = 2'b10;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       pc_sel;
        logic [3:0] alu_ctrl;
        logic       illegal_op;
    } ctrl_t;

    // Quiescent control word: every strobe low, ALU left on add.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = c_alu_add;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mc_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control_if
// Brief    : Control/status bundle between the multicycle control FSM (master)
//            and the MIPS datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mips_mc_control_if;
    logic [5:0] Op;
    logic [5:0] Function;
    logic       Zero;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       PCSel;
    logic [3:0] ALUCtrl;
    logic [3:0] state_o;
    logic       illegal_op;

    modport master (
        input  Op, Function, Zero,
        output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcB,
               ALUSrcA, RegWrite, RegDst, PCSel, ALUCtrl, state_o, illegal_op
    );

    modport slave (
        output Op, Function, Zero,
        input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcB,
               ALUSrcA, RegWrite, RegDst, PCSel, ALUCtrl, state_o, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/mips_mc_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_decoder
// Brief    : Maps an R-type Function field to an ALU control code; o_valid
//            is low for encodings the ALU does not implement.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_decoder (
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctrl,
    output logic       o_valid
);
    import mips_ctrl_pkg::*;

    always_comb begin
        o_alu_ctrl = c_alu_add;
        o_valid    = 1'b1;
        case (i_funct)
            c_fn_add: o_alu_ctrl = c_alu_add;
            c_fn_sub: o_alu_ctrl = c_alu_sub;
            c_fn_and: o_alu_ctrl = c_alu_and;
            c_fn_or:  o_alu_ctrl = c_alu_or;
            c_fn_slt: o_alu_ctrl = c_alu_slt;
            c_fn_nor: o_alu_ctrl = c_alu_nor;
            c_fn_xor: o_alu_ctrl = c_alu_xor;
            default:  o_valid    = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Brief    : Multicycle MIPS control FSM (R-type, lw, sw, beq, j, addi).
//            Optional bne support when MIPS_CTRL_BNE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    mips_mc_control_if.master bus
);
    import mips_ctrl_pkg::*;

    state_e     state_q;
    state_e     state_d;
    state_e     w_illegal_next;
    ctrl_t      w_ctrl;
    logic [3:0] w_dec_alu;
    logic       w_dec_valid;
    logic       w_branch_taken;

    mips_alu_decoder u_alu_dec (
        .i_funct    (bus.Function),
        .o_alu_ctrl (w_dec_alu),
        .o_valid    (w_dec_valid)
    );

    generate
        if (ILLEGAL_TRAP != 0) begin : g_trap
            assign w_illegal_next = ST_HALT;
        end else begin : g_no_trap
            assign w_illegal_next = ST_FETCH;
        end
    endgenerate

    // Op still holds the branch instruction in BRANCH, so it selects the sense.
`ifdef MIPS_CTRL_BNE_EN
    assign w_branch_taken = (bus.Op == c_op_bne) ? ~bus.Zero : bus.Zero;
`else
    assign w_branch_taken = bus.Zero;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_INIT;
        w_ctrl  = ctrl_idle();
        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.alu_src_b = c_srcb_one;
                w_ctrl.pc_source = c_pcsrc_alu;
                w_ctrl.pc_sel    = 1'b1;
                state_d          = ST_DECODE;
            end
            ST_DECODE: begin
                w_ctrl.alu_src_b = c_srcb_imm;
                case (bus.Op)
                    c_op_rtype:       state_d = ST_RTEXE;
                    c_op_lw, c_op_sw: state_d = ST_MEMADR;
                    c_op_beq:         state_d = ST_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    c_op_bne:         state_d = ST_BRANCH;
`endif
                    c_op_j:           state_d = ST_JUMP;
                    c_op_addi:        state_d = ST_ADDIEXE;
                    default: begin
                        w_ctrl.illegal_op = 1'b1;
                        state_d           = w_illegal_next;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
                state_d          = (bus.Op == c_op_lw) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.mem_read = 1'b1;
                state_d         = ST_MEMWB;
            end
            ST_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                state_d           = ST_FETCH;
            end
            ST_MEMWR: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_RTEXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_b;
                w_ctrl.alu_ctrl  = w_dec_alu;
                if (w_dec_valid) begin
                    state_d = ST_RTWB;
                end else begin
                    w_ctrl.illegal_op = 1'b1;
                    state_d           = w_illegal_next;
                end
            end
            ST_RTWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_b;
                w_ctrl.alu_ctrl  = c_alu_sub;
                w_ctrl.pc_source = c_pcsrc_aluout;
                w_ctrl.pc_sel    = w_branch_taken;
                state_d          = ST_FETCH;
            end
            ST_JUMP: begin
                w_ctrl.pc_source = c_pcsrc_jump;
                w_ctrl.pc_sel    = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_ADDIEXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_srcb_imm;
                state_d          = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
                state_d          = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign bus.IorD       = w_ctrl.iord;
    assign bus.MemRead    = w_ctrl.mem_read;
    assign bus.MemWrite   = w_ctrl.mem_write;
    assign bus.MemtoReg   = w_ctrl.mem_to_reg;
    assign bus.IRWrite    = w_ctrl.ir_write;
    assign bus.PCSource   = w_ctrl.pc_source;
    assign bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign bus.RegWrite   = w_ctrl.reg_write;
    assign bus.RegDst     = w_ctrl.reg_dst;
    assign bus.PCSel      = w_ctrl.pc_sel;
    assign bus.ALUCtrl    = w_ctrl.alu_ctrl;
    assign bus.illegal_op = w_ctrl.illegal_op;
    assign bus.state_o    = state_q;

endmodule
`default_nettype wire
